// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register rename status and commit bypass
module reg_status_file #(
   parameter int REG_NUM   = 32,
   parameter int REG_IDX_W = 5,
   parameter int DATA_W    = 32,
   parameter int ROB_ID_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   output logic                 rs1_ready,
   output logic [DATA_W-1:0]    rs1_value,
   output logic [ROB_ID_W-1:0]  rs1_rob_id,
   output logic                 rs2_ready,
   output logic [DATA_W-1:0]    rs2_value,
   output logic [ROB_ID_W-1:0]  rs2_rob_id,
   input  logic                 id_rename_valid,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic [ROB_ID_W-1:0]  id_rob_id,
   input  logic                 rob_commit_valid,
   input  logic [REG_IDX_W-1:0] rob_commit_rd,
   input  logic [ROB_ID_W-1:0]  rob_commit_id,
   input  logic [DATA_W-1:0]    rob_commit_value,
   input  logic                 roll_back_flag
);
   logic [DATA_W-1:0]    r_value [REG_NUM];
   logic [ROB_ID_W-1:0]  r_tag   [REG_NUM];
   logic [REG_NUM-1:0]   r_busy;
   logic [REG_IDX_W-1:0] w_idx   [2];
   logic                 w_ready [2];
   logic [DATA_W-1:0]    w_val   [2];
   logic [ROB_ID_W-1:0]  w_rob   [2];

   assign w_idx[0]   = id_rs1;
   assign w_idx[1]   = id_rs2;
   assign rs1_ready  = w_ready[0];
   assign rs1_value  = w_val[0];
   assign rs1_rob_id = w_rob[0];
   assign rs2_ready  = w_ready[1];
   assign rs2_value  = w_val[1];
   assign rs2_rob_id = w_rob[1];

   // state update: commit writes value, rename (listed last) overrides busy/tag, flush clears busy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
      end else if (rdy) begin
         if (roll_back_flag)
            r_busy <= '0;
         if (rob_commit_valid && rob_commit_rd != '0) begin
            r_value[rob_commit_rd] <= rob_commit_value;
            if (r_tag[rob_commit_rd] == rob_commit_id)
               r_busy[rob_commit_rd] <= 1'b0;
         end
         if (id_rename_valid && id_rd != '0 && !roll_back_flag) begin
            r_busy[id_rd] <= 1'b1;
            r_tag[id_rd]  <= id_rob_id;
         end
      end
   end

   // operand lookup on the pre-rename map, with same-cycle commit bypass
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_ready[p] = 1'b1;
         w_val[p]   = '0;
         w_rob[p]   = '0;
         if (!rst && w_idx[p] != '0) begin
            if (!r_busy[w_idx[p]])
               w_val[p] = r_value[w_idx[p]];
            else if (rob_commit_valid && rob_commit_rd == w_idx[p] && rob_commit_id == r_tag[w_idx[p]])
               w_val[p] = rob_commit_value;
            else begin
               w_ready[p] = 1'b0;
               w_rob[p]   = r_tag[w_idx[p]];
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed scoreboard bench for reg_status_file
module tb_reg_status_file;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, rob_commit_rd = '0;
   logic        rs1_ready, rs2_ready;
   logic [31:0] rs1_value, rs2_value;
   logic [3:0]  rs1_rob_id, rs2_rob_id;
   logic        id_rename_valid = 1'b0, rob_commit_valid = 1'b0, roll_back_flag = 1'b0;
   logic [3:0]  id_rob_id = '0, rob_commit_id = '0;
   logic [31:0] rob_commit_value = '0;
   logic        chk = 1'b0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      string       n;
      logic        r1;
      logic [31:0] v1;
      logic [3:0]  t1;
      logic        r2;
      logic [31:0] v2;
      logic [3:0]  t2;
   } exp_t;
   exp_t q[$];
   exp_t m_e;

   reg_status_file dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .rs1_ready(rs1_ready), .rs1_value(rs1_value), .rs1_rob_id(rs1_rob_id),
      .rs2_ready(rs2_ready), .rs2_value(rs2_value), .rs2_rob_id(rs2_rob_id),
      .id_rename_valid(id_rename_valid), .id_rd(id_rd), .id_rob_id(id_rob_id),
      .rob_commit_valid(rob_commit_valid), .rob_commit_rd(rob_commit_rd),
      .rob_commit_id(rob_commit_id), .rob_commit_value(rob_commit_value),
      .roll_back_flag(roll_back_flag)
   );

   always #5 clk = ~clk;

   // monitor: whenever a read is presented, pop the expected response and compare both ports
   always @(negedge clk) begin
      if (chk) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: read presented with no expected entry");
         end else begin
            m_e = q.pop_front();
            checks += 2;
            if ({rs1_ready, rs1_value, rs1_rob_id} !== {m_e.r1, m_e.v1, m_e.t1}) begin
               errors++;
               $display("FAIL %s rs1: got ready=%0b value=%h rob_id=%0d, want ready=%0b value=%h rob_id=%0d",
                        m_e.n, rs1_ready, rs1_value, rs1_rob_id, m_e.r1, m_e.v1, m_e.t1);
            end
            if ({rs2_ready, rs2_value, rs2_rob_id} !== {m_e.r2, m_e.v2, m_e.t2}) begin
               errors++;
               $display("FAIL %s rs2: got ready=%0b value=%h rob_id=%0d, want ready=%0b value=%h rob_id=%0d",
                        m_e.n, rs2_ready, rs2_value, rs2_rob_id, m_e.r2, m_e.v2, m_e.t2);
            end
         end
      end
   end

   task automatic drv(input logic ren, input logic [4:0] rd, input logic [3:0] rid,
                      input logic cv, input logic [4:0] crd, input logic [3:0] cid,
                      input logic [31:0] cval, input logic rb, input logic [4:0] a, input logic [4:0] b);
      id_rename_valid  = ren;
      id_rd            = rd;
      id_rob_id        = rid;
      rob_commit_valid = cv;
      rob_commit_rd    = crd;
      rob_commit_id    = cid;
      rob_commit_value = cval;
      roll_back_flag   = rb;
      id_rs1           = a;
      id_rs2           = b;
   endtask

   task automatic rd2(input logic [4:0] a, input logic [4:0] b);
      drv(0, 0, 0, 0, 0, 0, 0, 0, a, b);
   endtask

   task automatic expect2(input string n, input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [3:0] t2);
      q.push_back('{n, r1, v1, t1, r2, v2, t2});
      chk = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   initial begin
      rd2(5, 0);
      tick();
      expect2("reset_forced", 1, 0, 0, 1, 0, 0);
      tick();
      rst = 1'b0;
      rd2(5, 0);
      expect2("after_reset", 1, 0, 0, 1, 0, 0);
      tick();
      drv(1, 0, 3, 1, 0, 3, 32'h123, 0, 0, 0);
      expect2("x0_write_cycle", 1, 0, 0, 1, 0, 0);
      tick();
      rd2(0, 0);
      expect2("x0_ignored", 1, 0, 0, 1, 0, 0);
      tick();
      drv(1, 5, 7, 0, 0, 0, 0, 0, 5, 5);
      expect2("rename_reads_old", 1, 0, 0, 1, 0, 0);
      tick();
      rd2(5, 6);
      expect2("x5_busy", 0, 0, 7, 1, 0, 0);
      tick();
      drv(0, 0, 0, 1, 5, 7, 32'hDEADBEEF, 0, 5, 6);
      expect2("x5_bypass", 1, 32'hDEADBEEF, 0, 1, 0, 0);
      tick();
      rd2(5, 6);
      expect2("x5_committed", 1, 32'hDEADBEEF, 0, 1, 0, 0);
      tick();
      drv(1, 6, 2, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(1, 6, 9, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rd2(6, 5);
      expect2("x6_tag9", 0, 0, 9, 1, 32'hDEADBEEF, 0);
      tick();
      drv(0, 0, 0, 1, 6, 2, 32'h11, 0, 6, 6);
      expect2("x6_stale_commit_no_bypass", 0, 0, 9, 0, 0, 9);
      tick();
      rd2(6, 0);
      expect2("x6_still_busy", 0, 0, 9, 1, 0, 0);
      tick();
      drv(0, 0, 0, 1, 6, 9, 32'h22, 0, 6, 0);
      expect2("x6_bypass_22", 1, 32'h22, 0, 1, 0, 0);
      tick();
      rd2(6, 0);
      expect2("x6_ready_22", 1, 32'h22, 0, 1, 0, 0);
      tick();
      drv(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(1, 8, 4, 1, 8, 1, 32'h55, 0, 8, 0);
      expect2("x8_rename_commit_bypass", 1, 32'h55, 0, 1, 0, 0);
      tick();
      rd2(8, 0);
      expect2("x8_rename_wins", 0, 0, 4, 1, 0, 0);
      tick();
      drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(1, 2, 2, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rd2(3, 1);
      expect2("x3_x1_busy", 0, 0, 3, 0, 0, 1);
      tick();
      drv(1, 4, 5, 1, 2, 2, 32'h77, 1, 2, 4);
      expect2("flush_cycle", 1, 32'h77, 0, 1, 0, 0);
      tick();
      rd2(1, 2);
      expect2("flush_x1_x2", 1, 0, 0, 1, 32'h77, 0);
      tick();
      rd2(3, 4);
      expect2("flush_x3_x4", 1, 0, 0, 1, 0, 0);
      tick();
      rd2(8, 6);
      expect2("flush_x8_value", 1, 32'h55, 0, 1, 32'h22, 0);
      tick();
      rdy = 1'b0;
      drv(1, 7, 6, 1, 5, 0, 32'h99, 0, 7, 5);
      expect2("frozen_cycle", 1, 0, 0, 1, 32'hDEADBEEF, 0);
      tick();
      rdy = 1'b1;
      rd2(7, 5);
      expect2("frozen_no_change", 1, 0, 0, 1, 32'hDEADBEEF, 0);
      tick();
      drv(1, 9, 11, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rdy = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      rdy = 1'b1;
      rd2(9, 0);
      expect2("frozen_flush_ignored", 0, 0, 11, 1, 0, 0);
      tick();
      rst = 1'b1;
      rd2(9, 5);
      expect2("mid_reset_forced", 1, 0, 0, 1, 0, 0);
      tick();
      rst = 1'b0;
      rd2(9, 5);
      expect2("post_reset_cleared", 1, 0, 0, 1, 0, 0);
      tick();
      rd2(6, 8);
      expect2("post_reset_x6_x8", 1, 0, 0, 1, 0, 0);
      tick();
      rd2(0, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++)
         tick();
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
